// File: rtl/tl_cntr_timed.sv
// Timed two-road traffic-light controller: Moore FSM with per-state cycle timer,
// min/max green, yellow and all-red clearance. Define TL_PED_EN to add the pedestrian walk phase.
module tl_cntr_timed #(
   parameter int CNT_W      = 8,
   parameter int GREEN_MIN  = 4,
   parameter int GREEN_MAX  = 10,
   parameter int YELLOW_CYC = 2,
   parameter int ALLRED_CYC = 1,
   parameter int WALK_CYC   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Ta,
   input  logic       Tb,
`ifdef TL_PED_EN
   input  logic       ped_req,
   output logic       walk,
`endif
   output logic [1:0] La,
   output logic [1:0] Lb,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      A_GRN  = 3'd0,
      A_YEL  = 3'd1,
      AB_RED = 3'd2,
      B_GRN  = 3'd3,
      B_YEL  = 3'd4,
      BA_RED = 3'd5,
      PED    = 3'd6
   } state_t;

   localparam logic [1:0] GREEN  = 2'b00;
   localparam logic [1:0] YELLOW = 2'b01;
   localparam logic [1:0] RED    = 2'b10;

   // Thresholds are "cycles already completed", hence the -1.
   localparam logic [CNT_W-1:0] GMIN_T = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GMAX_T = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] YEL_T  = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] AR_T   = CNT_W'(ALLRED_CYC - 1);
   localparam logic [CNT_W-1:0] WALK_T = CNT_W'(WALK_CYC - 1);

   if (GREEN_MIN < 1 || GREEN_MAX <= GREEN_MIN || YELLOW_CYC < 1 || ALLRED_CYC < 1 ||
       WALK_CYC < 1 || GREEN_MAX > (2**CNT_W - 1) || YELLOW_CYC > (2**CNT_W - 1) ||
       ALLRED_CYC > (2**CNT_W - 1) || WALK_CYC > (2**CNT_W - 1)) begin : g_param_check
      $error("tl_cntr_timed: duration parameters out of range");
   end

   state_t           cur_state;
   state_t           nxt_state;
   logic [CNT_W-1:0] timer;
   logic             ped_pend;

   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         A_GRN: begin
            if ((timer >= GMIN_T && !Ta) || (timer >= GMAX_T && Tb))
               nxt_state = A_YEL;
         end
         A_YEL: begin
            if (timer == YEL_T)
               nxt_state = AB_RED;
         end
         AB_RED: begin
            if (timer == AR_T)
               nxt_state = B_GRN;
         end
         B_GRN: begin
            if ((timer >= GMIN_T && !Tb) || (timer >= GMAX_T && Ta))
               nxt_state = B_YEL;
         end
         B_YEL: begin
            if (timer == YEL_T)
               nxt_state = BA_RED;
         end
         BA_RED: begin
            if (timer == AR_T)
               nxt_state = ped_pend ? PED : A_GRN;
         end
`ifdef TL_PED_EN
         PED: begin
            if (timer == WALK_T)
               nxt_state = A_GRN;
         end
`endif
         // Unused encodings fall back to A_GRN; the state change also clears the timer.
         default: nxt_state = A_GRN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= A_GRN;
         timer     <= '0;
      end else begin
         cur_state <= nxt_state;
         if (nxt_state != cur_state)
            timer <= '0;
         else if (timer != {CNT_W{1'b1}})
            timer <= timer + 1'b1;
      end
   end

`ifdef TL_PED_EN
   // A request sampled on the very edge that enters PED is kept for the next walk.
   always_ff @(posedge clk) begin
      if (reset)
         ped_pend <= 1'b0;
      else if (nxt_state == PED && cur_state != PED)
         ped_pend <= ped_req;
      else if (ped_req)
         ped_pend <= 1'b1;
   end
`else
   assign ped_pend = 1'b0;
`endif

   always_comb begin
      La = RED;
      Lb = RED;
      case (cur_state)
         A_GRN:   La = GREEN;
         A_YEL:   La = YELLOW;
         B_GRN:   Lb = GREEN;
         B_YEL:   Lb = YELLOW;
         default: ;
      endcase
   end

`ifdef TL_PED_EN
   assign walk = (cur_state == PED);
`endif

   assign state = cur_state;

endmodule

// File: tb/tb_tl_cntr_timed.sv
// Randomised self-checking bench for tl_cntr_timed against a dwell-count reference model.
module tb_tl_cntr_timed;

   localparam int GMIN = 4, GMAX = 10, YEL = 2, AR = 1, WLK = 3;
`ifdef TL_PED_EN
   localparam bit PED_EN = 1'b1;
`else
   localparam bit PED_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, Ta, Tb;
   logic [1:0] La, Lb;
   logic [2:0] state;
`ifdef TL_PED_EN
   logic       ped_req, walk;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: current phase, cycles completed in it, pending walk request.
   int m_st = 0;
   int m_t  = 0;
   bit m_pend = 1'b0;

   int seq14[14] = '{0,0,0,0,1,1,2,3,3,3,3,4,4,5};
   int seq26[26] = '{0,0,0,0,0,0,0,0,0,0,1,1,2,3,3,3,3,3,3,3,3,3,3,4,4,5};

   tl_cntr_timed dut (
      .clk    (clk),
      .reset  (reset),
      .Ta     (Ta),
      .Tb     (Tb),
`ifdef TL_PED_EN
      .ped_req(ped_req),
      .walk   (walk),
`endif
      .La     (La),
      .Lb     (Lb),
      .state  (state)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] exp_la(input int s);
      if (s == 0) return 2'b00;
      if (s == 1) return 2'b01;
      return 2'b10;
   endfunction

   function automatic logic [1:0] exp_lb(input int s);
      if (s == 3) return 2'b00;
      if (s == 4) return 2'b01;
      return 2'b10;
   endfunction

   task automatic model_edge(input bit rst, input bit ta, input bit tb, input bit pr);
      int done;
      int nxt;
      if (rst) begin
         m_st = 0; m_t = 0; m_pend = 1'b0;
         return;
      end
      done = m_t + 1;
      nxt  = m_st;
      case (m_st)
         0: if ((done >= GMIN && !ta) || (done >= GMAX && tb)) nxt = 1;
         1: if (done == YEL) nxt = 2;
         2: if (done == AR) nxt = 3;
         3: if ((done >= GMIN && !tb) || (done >= GMAX && ta)) nxt = 4;
         4: if (done == YEL) nxt = 5;
         5: if (done == AR) nxt = (PED_EN && m_pend) ? 6 : 0;
         6: if (done == WLK) nxt = 0;
         default: nxt = 0;
      endcase
      if (nxt == 6 && m_st != 6) m_pend = pr;
      else if (pr) m_pend = 1'b1;
      m_t  = (nxt != m_st) ? 0 : ((m_t < 255) ? m_t + 1 : 255);
      m_st = nxt;
   endtask

   task automatic step(input bit rst, input bit ta, input bit tb, input bit pr);
      reset = rst; Ta = ta; Tb = tb;
`ifdef TL_PED_EN
      ped_req = pr;
`endif
      @(posedge clk);
      model_edge(rst, ta, tb, pr);
      #1;
   endtask

   task automatic test_reset;
      int guard;
      step(1, 0, 0, 0);
      guard = 0;
      while (m_st != 4 && guard < 40) begin
         step(0, 0, 0, 0);
         guard++;
      end
      total++;
      if (int'(state) !== 4) begin
         bad++;
         $display("FAIL reset_reach_b_yel: state=%0d want=4", state);
      end
      for (int i = 0; i < 2; i++) begin
         step(1, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
         total++;
         if ({state, La, Lb} !== {3'd0, 2'b00, 2'b10}) begin
            bad++;
            $display("FAIL reset_out%0d: state=%0d La=%b Lb=%b want 0/00/10", i, state, La, Lb);
         end
`ifdef TL_PED_EN
         total++;
         if (walk !== 1'b0) begin
            bad++;
            $display("FAIL reset_walk: walk=%b want 0", walk);
         end
`endif
      end
   endtask

   task automatic test_idle_cycle;
      step(1, 0, 0, 0);
      for (int p = 0; p < 28; p++) begin
         step(0, 0, 0, 0);
         total++;
         if (int'(state) !== seq14[(p + 1) % 14] || La !== exp_la(seq14[(p + 1) % 14]) ||
             Lb !== exp_lb(seq14[(p + 1) % 14])) begin
            bad++;
            $display("FAIL idle_seq[%0d]: state=%0d La=%b Lb=%b want state=%0d", p, state, La, Lb,
                     seq14[(p + 1) % 14]);
         end
      end
   endtask

   task automatic test_hold_a;
      int wrong = 0;
      step(1, 1, 0, 0);
      for (int i = 0; i < 50; i++) begin
         step(0, 1, 0, 0);
         if (state !== 3'd0 || La !== 2'b00) wrong++;
      end
      total++;
      if (wrong != 0) begin
         bad++;
         $display("FAIL hold_a: %0d of 50 cycles left A_GRN, want 0", wrong);
      end
      step(0, 0, 0, 0);
      total++;
      if (state !== 3'd1 || La !== 2'b01) begin
         bad++;
         $display("FAIL hold_a_release: state=%0d La=%b want 1/01", state, La);
      end
   endtask

   task automatic test_both_demand;
      step(1, 1, 1, 0);
      for (int p = 0; p < 52; p++) begin
         step(0, 1, 1, 0);
         total++;
         if (int'(state) !== seq26[(p + 1) % 26]) begin
            bad++;
            $display("FAIL both_seq[%0d]: state=%0d want %0d", p, state, seq26[(p + 1) % 26]);
         end
      end
   endtask

   task automatic test_clearance_toggle;
      int n;
      int guard;
      step(1, 0, 1, 0);
      guard = 0;
      while (state !== 3'd1 && guard < 20) begin
         step(0, 0, 1, 0);
         guard++;
      end
      n = 1;
      guard = 0;
      while (guard < 10) begin
         step(0, guard[0], ~guard[0], 0);
         guard++;
         if (state !== 3'd1) break;
         n++;
      end
      total++;
      if (n != YEL || state !== 3'd2) begin
         bad++;
         $display("FAIL toggle_yellow: dwell=%0d next=%0d want %0d then 2", n, state, YEL);
      end
      n = 1;
      guard = 0;
      while (guard < 10) begin
         step(0, ~guard[0], guard[0], 0);
         guard++;
         if (state !== 3'd2) break;
         n++;
      end
      total++;
      if (n != AR || state !== 3'd3) begin
         bad++;
         $display("FAIL toggle_allred: dwell=%0d next=%0d want %0d then 3", n, state, AR);
      end
   endtask

   task automatic test_random;
      bit ta = 0, tb = 0, rst, pr;
      int prev = 0;
      int run  = 1;
      step(1, 0, 0, 0);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) ta = ~ta;
         if ($urandom_range(0, 7) == 0) tb = ~tb;
         rst = ($urandom_range(0, 79) == 0);
         pr  = ($urandom_range(0, 24) == 0);
         step(rst, ta, tb, pr);
         total++;
         if ({state, La, Lb} !== {3'(m_st), exp_la(m_st), exp_lb(m_st)}) begin
            bad++;
            $display("FAIL random[%0d]: state=%0d La=%b Lb=%b want %0d/%b/%b", i, state, La, Lb,
                     m_st, exp_la(m_st), exp_lb(m_st));
         end
`ifdef TL_PED_EN
         total++;
         if (walk !== (m_st == 6)) begin
            bad++;
            $display("FAIL random_walk[%0d]: walk=%b want %b", i, walk, m_st == 6);
         end
`endif
         if (rst) begin
            prev = int'(state); run = 1;
         end else if (int'(state) == prev) begin
            run++;
         end else begin
            if (prev == 1 || prev == 4) begin
               total++;
               if (run != YEL) begin
                  bad++;
                  $display("FAIL random_yellow_dwell: got=%0d want=%0d", run, YEL);
               end
            end else if (prev == 2 || prev == 5) begin
               total++;
               if (run != AR) begin
                  bad++;
                  $display("FAIL random_allred_dwell: got=%0d want=%0d", run, AR);
               end
            end
            prev = int'(state); run = 1;
         end
      end
   endtask

`ifdef TL_PED_EN
   task automatic test_ped;
      int guard;
      int n;
      step(1, 0, 0, 0);
      guard = 0;
      while (state !== 3'd3 && guard < 20) begin
         step(0, 0, 0, 0);
         guard++;
      end
      step(0, 0, 0, 1);
      guard = 0;
      while (state !== 3'd6 && guard < 20) begin
         step(0, 0, 0, 0);
         guard++;
      end
      n = 0;
      guard = 0;
      while (state === 3'd6 && guard < 10) begin
         n++;
         total++;
         if (walk !== 1'b1 || La !== 2'b10 || Lb !== 2'b10) begin
            bad++;
            $display("FAIL ped_lamps: walk=%b La=%b Lb=%b want 1/10/10", walk, La, Lb);
         end
         step(0, 0, 0, 0);
         guard++;
      end
      total++;
      if (n != WLK || state !== 3'd0 || walk !== 1'b0) begin
         bad++;
         $display("FAIL ped_dwell: dwell=%0d next=%0d want %0d then 0", n, state, WLK);
      end
      guard = 0;
      while (state !== 3'd5 && guard < 30) begin
         step(0, 0, 0, 0);
         guard++;
      end
      step(0, 0, 0, 0);
      total++;
      if (state !== 3'd0) begin
         bad++;
         $display("FAIL ped_once: after BA_RED state=%0d want 0", state);
      end
   endtask
`endif

   initial begin
      reset = 1'b1; Ta = 1'b0; Tb = 1'b0;
`ifdef TL_PED_EN
      ped_req = 1'b0;
`endif
      test_reset();
      test_idle_cycle();
      test_hold_a();
      test_both_demand();
      test_clearance_toggle();
`ifdef TL_PED_EN
      test_ped();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
